// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 8:1 mux.
// Each grant is bounded to MAX_HOLD cycles and is followed by a single idle bubble.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    input  logic [7:0] I,
    output logic [7:0] grant,
    output logic       valid,
    output logic       S2,
    output logic       S1,
    output logic       S0,
    output logic       Y
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [2:0]          ptr_r;
    logic [2:0]          ptr_nxt_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [HOLD_W-1:0]   hold_nxt_s;
    logic [7:0]          grant_nxt_s;
    logic                valid_nxt_s;
    logic [2:0]          sel_s;
    logic [2:0]          sel_nxt_s;
    logic                y_nxt_s;
    logic [2:0]          win_idx_s;
    logic                win_found_s;
    logic                release_s;

    assign sel_s = {S2, S1, S0};

    // Rotating priority scan: walking offsets from far to near leaves the nearest requester.
    always_comb begin
        win_idx_s   = 3'd0;
        win_found_s = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            win_idx_s   = req[ptr_r + 3'(k)] ? (ptr_r + 3'(k)) : win_idx_s;
            win_found_s = win_found_s | req[ptr_r + 3'(k)];
        end
    end

    // Grant ends on explicit release, when the owner withdraws, or when its hold budget runs out.
    always_comb begin
        release_s = done | ~req[sel_s] | (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));
    end

    // Next-state and next-output logic for the two-state arbiter.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        hold_nxt_s  = hold_cnt_r;
        grant_nxt_s = grant;
        valid_nxt_s = valid;
        sel_nxt_s   = sel_s;
        y_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                grant_nxt_s = 8'h00;
                valid_nxt_s = 1'b0;
                if (win_found_s) begin
                    state_nxt_s = GRANT;
                    grant_nxt_s = 8'h01 << win_idx_s;
                    sel_nxt_s   = win_idx_s;
                    valid_nxt_s = 1'b1;
                    hold_nxt_s  = {HOLD_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = 8'h00;
                    valid_nxt_s = 1'b0;
                    ptr_nxt_s   = sel_s + 3'd1;
                end else begin
                    hold_nxt_s  = hold_cnt_r + HOLD_W'(1);
                    y_nxt_s     = I[sel_s];
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = 8'h00;
                valid_nxt_s = 1'b0;
                hold_nxt_s  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ptr_r        <= 3'd0;
            hold_cnt_r   <= {HOLD_W{1'b0}};
            grant        <= 8'h00;
            valid        <= 1'b0;
            {S2, S1, S0} <= 3'b000;
            Y            <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            hold_cnt_r   <= hold_nxt_s;
            grant        <= grant_nxt_s;
            valid        <= valid_nxt_s;
            {S2, S1, S0} <= sel_nxt_s;
            Y            <= y_nxt_s;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios then random traffic,
// all checked against an owner/age reference model.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] I;
    logic [7:0] grant;
    logic       valid;
    logic       S2, S1, S0, Y;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: who owns the mux, how many cycles it has had, whose turn is next.
    bit m_busy;
    int m_owner;
    int m_age;
    int m_ptr;
    int m_sel;
    bit m_y;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .I(I),
        .grant(grant), .valid(valid), .S2(S2), .S1(S1), .S0(S0), .Y(Y)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_busy = 1'b0; m_ptr = 0; m_sel = 0; m_y = 1'b0; m_age = 0;
        end else if (!m_busy) begin
            m_y = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && req[(m_ptr + k) % 8]) begin
                    m_busy = 1'b1; m_owner = (m_ptr + k) % 8; m_sel = m_owner; m_age = 1;
                end
            end
        end else if (done || !req[m_owner] || m_age == MAX_HOLD) begin
            m_busy = 1'b0; m_ptr = (m_owner + 1) % 8; m_y = 1'b0;
        end else begin
            m_age++; m_y = I[m_owner];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_val("grant", {24'd0, grant}, m_busy ? (32'd1 << m_owner) : 32'd0);
        check_val("valid", {31'd0, valid}, {31'd0, m_busy});
        check_val("sel",   {29'd0, S2, S1, S0}, 32'(m_sel));
        check_val("y",     {31'd0, Y}, {31'd0, m_y});
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 8'hFF; done = 1'b0; I = 8'h00;

        // Reset with all requesting, then first grant to requester 0
        do_reset(2);
        check_val("rst_grant", {24'd0, grant}, 32'h00);
        step();
        check_val("t1_grant0", {24'd0, grant}, 32'h01);

        // Full round-robin sweep with timeout releases
        I = 8'b10011100;
        repeat (42) step();

        // Early release by done on second grant cycle
        do_reset(1);
        req = 8'h24;
        step();
        check_val("t3_grant2", {24'd0, grant}, 32'h04);
        step();
        done = 1'b1; step(); done = 1'b0;
        check_val("t3_idle", {31'd0, valid}, 32'd0);
        step();
        check_val("t3_grant5", {24'd0, grant}, 32'h20);
        check_val("t3_sel5", {29'd0, S2, S1, S0}, 32'd5);

        // Request drop then pointer wrap from 7 to 0
        do_reset(1);
        req = 8'h40;
        step(); step();
        req = 8'h01; step();
        req = 8'h41; step();
        check_val("t4_wrap0", {24'd0, grant}, 32'h01);

        // Reset in the middle of a grant
        do_reset(1);
        req = 8'h10;
        repeat (3) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check_val("t5_rst_grant", {24'd0, grant}, 32'h00);
        req = 8'h11; step();
        check_val("t5_grant0", {24'd0, grant}, 32'h01);

        // Long idle then a lone top requester
        do_reset(1);
        req = 8'h00;
        repeat (10) step();
        req = 8'h80; step();
        check_val("t6_grant7", {24'd0, grant}, 32'h80);
        check_val("t6_sel7", {29'd0, S2, S1, S0}, 32'd7);

        // Random traffic; requests held for a while so timeouts occur
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 5) == 0)
                req = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            done = ($urandom_range(0, 7) == 0);
            I = 8'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares one 8:1 mux datapath among 8 requesters. It drives the mux select lines S2/S1/S0 and a one-hot grant vector. It registers the selected data bit onto Y while a grant is active. It sits in front of the structural 8:1 mux and sequences ownership of its select lines, with a bounded hold time per grant.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant (legal range 1..15)
HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req  input  8  request vector; req[k] high = requester k wants the mux
done  input  1  current grantee releases early; sampled only in GRANT
I  input  8  mux data inputs; I[k] belongs to requester k
grant  output  8  one-hot grant, all-zero when idle
valid  output  1  high while in GRANT
S2  output  1  select MSB
S1  output  1  select middle bit
S0  output  1  select LSB
Y  output  1  registered I[{S2,S1,S0}] while valid, else 0

Behaviour:
- Reset: synchronous active-low. When rst_n is low at a rising edge, all of the following apply on that edge, regardless of state or in-progress grant:
  - state=IDLE, ptr=0, hold_cnt=0
  - grant=8'h00, valid=0, {S2,S1,S0}=3'b000, Y=0
- Only registered outputs; no combinational path from inputs to outputs.
- ptr (3 bits): highest-priority requester index for the next arbitration.
- State IDLE:
  - If req==0: stay in IDLE, outputs held at idle values (grant=0, valid=0, Y=0; select keeps its last value).
  - Else: winner w = first k scanning ptr, ptr+1, ... wrapping mod 8 with req[k]=1.
  - Next edge: state=GRANT, grant=1<<w, {S2,S1,S0}=w, valid=1, hold_cnt=0.
  - Latency from a req asserting in IDLE to grant: 1 cycle.
- State GRANT, evaluated each edge with sel={S2,S1,S0}:
  - Release if done=1, or req[sel]=0, or hold_cnt==MAX_HOLD-1.
  - On release, next edge: state=IDLE, grant=0, valid=0, Y=0, ptr=(sel+1) mod 8 (3-bit wrap, 7->0). The select lines keep their value.
  - Otherwise: hold_cnt+=1, Y=I[sel].
- Y timing:
  - Y is registered. On the first GRANT cycle Y=0; from the second GRANT cycle on, Y equals I[sel] sampled on the prior edge.
  - Y returns to 0 on the edge that leaves GRANT.
- Each grant lasts 1..MAX_HOLD cycles with valid=1, followed by exactly one IDLE bubble cycle before any new grant.
- Fairness: under continuous requests from all 8, the grant order is 0,1,...,7,0,... Worst-case wait for any requester is 7*(MAX_HOLD+1) cycles.
- Simultaneous events:
  - done and hold timeout in the same cycle: a single release, ptr updated once.
  - done while in IDLE: ignored.
  - req of other requesters changing during GRANT: ignored until IDLE.
- Reset mid-grant: the grant drops on that edge and ptr returns to 0, so requester 0 has priority after reset.
- Select encoding: S2 is the MSB, S0 the LSB. sel=3'b101 selects I[5].

Test Plan:
1. Reset: rst_n=0 for 2 cycles with req=8'hFF -> grant=0, valid=0, S=000, Y=0. Release reset -> next edge grant=8'h01, S=000, valid=1.
2. Round-robin: req=8'hFF held, done=0, MAX_HOLD=4, I=8'b10011100 -> grants 0..7 in order, each valid 4 cycles plus 1 bubble. Y follows I[sel]: 0,0,1,1,1,0,0,1 from the second cycle of each grant.
3. Early release: req=8'h24, grant to 2; assert done on the 2nd GRANT cycle -> IDLE next edge, ptr=3. Next grant goes to 5 (S=101), not 2.
4. Request drop: grant to 6, deassert req[6] after 1 cycle -> release; ptr=7. With req=8'h41, the next grant is 0 (wrap), S=000.
5. Mid-grant reset: grant to 4 at hold_cnt=2, pull rst_n low one edge -> grant=0, Y=0 that edge. With req=8'h11 after reset, the grant goes to 0 (ptr=0).
6. Sparse/idle: req=0 for 10 cycles -> valid stays 0, Y=0. Then req=8'h80 -> grant=8'h80, S=111 one edge later.
